// File: rtl/bist_top.sv
// rtl/bist_top.sv - MBIST wrapper: single-port RAM, pattern engine, sticky fail flag
// Optional BIST_CHECKERBOARD_EN runs all 8 patterns; otherwise only 00 and FF.
module bist_top #(
    parameter int size   = 6,
    parameter int length = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              csin,
    input  logic              rwbarin,
    input  logic              opr,
    input  logic [size-1:0]   address,
    input  logic [length-1:0] datain,
    output logic [length-1:0] dataout,
    output logic              fail
);

`ifdef BIST_CHECKERBOARD_EN
    localparam int CNT_W = size + 4;
`else
    localparam int CNT_W = size + 2;
`endif
    localparam int PAT_W = CNT_W - size - 1;

    typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fail_q;

    logic              in_test;
    logic [2:0]        pat_idx;
    logic [length-1:0] bist_pat;
    logic              ram_cs;
    logic              ram_rwbar;
    logic [size-1:0]   ram_addr;
    logic [length-1:0] ram_wdata;
    logic [length-1:0] ram_rdata;
    logic [length-1:0] mem [2**size];

    // Byte pattern replicated across the word, LSB-aligned.
    function automatic logic [length-1:0] pattern_word(input logic [2:0] idx);
        logic [7:0]        b;
        logic [length-1:0] w;
        case (idx)
            3'd0:    b = 8'h00;
            3'd1:    b = 8'hFF;
            3'd2:    b = 8'hAA;
            3'd3:    b = 8'h55;
            3'd4:    b = 8'hCC;
            3'd5:    b = 8'h33;
            3'd6:    b = 8'hF0;
            default: b = 8'h0F;
        endcase
        for (int i = 0; i < length; i++) begin
            w[i] = b[i % 8];
        end
        return w;
    endfunction

    assign in_test  = (state_q == TEST);
    assign pat_idx  = 3'(cnt_q[CNT_W-1 -: PAT_W]);
    assign bist_pat = pattern_word(pat_idx);

    assign ram_cs    = in_test ? 1'b1               : csin;
    assign ram_rwbar = in_test ? cnt_q[size]        : rwbarin;
    assign ram_addr  = in_test ? cnt_q[size-1:0]    : address;
    assign ram_wdata = in_test ? bist_pat           : datain;

    always_ff @(posedge clk) begin
        if (ram_cs && !ram_rwbar) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    assign ram_rdata = mem[ram_addr];
    assign dataout   = (ram_cs && ram_rwbar) ? ram_rdata : '0;
    assign fail      = fail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (opr && start) begin
                        state_q <= TEST;
                        cnt_q   <= '0;
                        fail_q  <= 1'b0;
                    end
                end
                TEST: begin
                    if (!opr) begin
                        state_q <= IDLE;
                    end else begin
                        // Compare on the read pass only; fail is sticky until next launch.
                        if (cnt_q[size] && (dataout != bist_pat)) begin
                            fail_q <= 1'b1;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (&cnt_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!opr) begin
                        state_q <= IDLE;
                    end else if (start) begin
                        state_q <= TEST;
                        cnt_q   <= '0;
                        fail_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_top.sv
// tb/tb_bist_top.sv - randomized self-checking bench for bist_top against a pattern-sequence model
module tb_bist_top;

    localparam int SIZE  = 6;
    localparam int LEN   = 8;
    localparam int DEPTH = 2 ** SIZE;
`ifdef BIST_CHECKERBOARD_EN
    localparam int NPAT = 8;
`else
    localparam int NPAT = 2;
`endif
    localparam int NCYC = DEPTH * 2 * NPAT;
    localparam logic [7:0] PATS [8] = '{8'h00, 8'hFF, 8'hAA, 8'h55, 8'hCC, 8'h33, 8'hF0, 8'h0F};

    logic            clk = 1'b0;
    logic            rst, start, csin, rwbarin, opr;
    logic [SIZE-1:0] address;
    logic [LEN-1:0]  datain;
    logic [LEN-1:0]  dataout;
    logic            fail;

    bist_top #(.size(SIZE), .length(LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .csin    (csin),
        .rwbarin (rwbarin),
        .opr     (opr),
        .address (address),
        .datain  (datain),
        .dataout (dataout),
        .fail    (fail)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] model_mem [DEPTH];
    bit         fail_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic normal_write(input int a, input logic [7:0] d);
        csin = 1'b1; rwbarin = 1'b0; address = SIZE'(a); datain = d;
        step();
        model_mem[a] = d;
        csin = 1'b0;
    endtask

    task automatic normal_read(input string tag, input int a);
        csin = 1'b1; rwbarin = 1'b1; address = SIZE'(a);
        #1;
        check(tag, 32'(dataout), 32'(model_mem[a]));
        csin = 1'b0;
    endtask

    // Launch a run and follow it for stop_at TEST cycles, predicting every read and the fail flag.
    task automatic run_bist(input bit inject, input int stop_at);
        opr = 1'b1; start = 1'b1; csin = 1'b0; rwbarin = 1'b0;
        step();
        start = 1'b0;
        fail_exp = 1'b0;
        check("launch_clear", 32'(fail), 32'(fail_exp));
        for (int k = 0; k < stop_at; k++) begin
            int         a;
            int         p;
            bit         rd;
            bit         forced;
            logic [7:0] v;
            a  = k % DEPTH;
            rd = ((k / DEPTH) % 2) == 1;
            p  = k / (2 * DEPTH);
            v  = PATS[p];
            forced = inject && rd && (a == 5) && (p == 1);
            if (forced) begin
                force dut.ram_rdata = 8'hFE;
                v = 8'hFE;
            end
            #1;
            check("bist_dataout", 32'(dataout), rd ? 32'(v) : 32'd0);
            if (!rd) model_mem[a] = PATS[p];
            if (rd && (v != PATS[p])) fail_exp = 1'b1;
            step();
            if (forced) release dut.ram_rdata;
            check("bist_fail", 32'(fail), 32'(fail_exp));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; csin = 1'b0; rwbarin = 1'b1; opr = 1'b0;
        address = '0; datain = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        step(); step();
        rst = 1'b0;
        #1;
        check("reset_fail", 32'(fail), 32'd0);
        check("reset_dataout", 32'(dataout), 32'd0);

        normal_write(17, 8'hA5);
        normal_read("directed_a5", 17);

        for (int i = 0; i < 100; i++) begin
            int         a;
            logic [7:0] d;
            a = int'($urandom_range(0, DEPTH - 1));
            d = 8'($urandom);
            normal_write(a, d);
            normal_read("rand_rw", a);
        end
        check("rand_fail", 32'(fail), 32'd0);

        // rst wins over a simultaneous start: machine must remain idle.
        opr = 1'b1; start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        normal_read("rst_beats_start", 17);

        for (int i = 0; i < 100; i++) begin
            step();
            if (i % 20 == 0) check("idle_fail", 32'(fail), 32'd0);
        end
        normal_read("idle_access", 17);

        run_bist(1'b0, NCYC);
        check("done_fail_good", 32'(fail), 32'd0);
        for (int i = 0; i < 4; i++) normal_read("done_contents", int'($urandom_range(0, DEPTH - 1)));
        step();
        normal_read("done_holds", 3);

        run_bist(1'b1, NCYC);
        check("fault_done_fail", 32'(fail), 32'd1);
        step(); step();
        check("fault_sticky", 32'(fail), 32'd1);

        run_bist(1'b1, 210);
        opr = 1'b0;
        step();
        check("abort_fail_kept", 32'(fail), 32'd1);
        normal_write(40, 8'h3C);
        normal_read("abort_normal", 40);

        run_bist(1'b1, 220);
        check("pre_reset_fail", 32'(fail), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_mid_test", 32'(fail), 32'd0);
        opr = 1'b1; start = 1'b0;
        normal_read("reset_idle", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
